sid_envelope: RTL and testbench

Per-voice ADSR envelope generator and VCA that sits directly downstream of `sid_voice`. It consumes the voice's 12-bit unsigned waveform, scales it by an 8-bit envelope, and produces a signed sample for the mixer. It decodes its own registers from the shared SID bus: gate bit at BASE+4 bit 0, AD at BASE+5, and SR at BASE+6. Bits 7:1 of BASE+4 belong to `sid_voice`.

---
 rtl/sid_envelope.sv | 158 +++++++++++++++
 tb/tb_sid_envelope.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_envelope.sv
// Per-voice SID ADSR envelope generator with a two-stage VCA that scales the
// 12-bit unsigned voice waveform by the 8-bit envelope into a signed sample.
module sid_envelope #(
  parameter logic [4:0] BASE_ADDR = 5'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLKen,
  input  logic        WR,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  DATA,
  input  logic [11:0] VOICE_IN,
  output logic [7:0]  ENV_OUT,
  output logic [15:0] OUTPUT
);

  localparam logic [4:0] ADDR_CTRL = BASE_ADDR + 5'd4;
  localparam logic [4:0] ADDR_AD   = BASE_ADDR + 5'd5;
  localparam logic [4:0] ADDR_SR   = BASE_ADDR + 5'd6;

  typedef enum logic [1:0] {ST_ATTACK, ST_DECAY_SUSTAIN, ST_RELEASE} state_t;

  state_t r_state, w_state_nxt;
  logic        r_gate, r_gate_lag;
  logic [7:0]  r_ad, r_sr;
  logic [7:0]  r_env, w_env_nxt;
  logic [14:0] r_rate_cnt, w_rate_nxt, w_period;
  logic [4:0]  r_exp_cnt, w_exp_nxt, w_exp_inc, w_exp_top;
  logic [3:0]  w_rate_idx;
  logic        w_tick, w_rise, w_fall;

  logic signed [12:0] r_vca_s;
  logic [7:0]         r_vca_env;
  logic signed [20:0] w_prod;
  logic [15:0]        r_out;
  logic               w_unused;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gate <= 1'b0;
      r_ad   <= '0;
      r_sr   <= '0;
    end else if (WR) begin
      case (ADDR)
        ADDR_CTRL: r_gate <= DATA[0];
        ADDR_AD:   r_ad   <= DATA;
        ADDR_SR:   r_sr   <= DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_RELEASE;
      r_env      <= '0;
      r_rate_cnt <= '0;
      r_exp_cnt  <= '0;
      r_gate_lag <= 1'b0;
    end else if (CLKen) begin
      r_state    <= w_state_nxt;
      r_env      <= w_env_nxt;
      r_rate_cnt <= w_rate_nxt;
      r_exp_cnt  <= w_exp_nxt;
      r_gate_lag <= r_gate;
    end
  end

  always_comb begin
    w_rate_idx = r_sr[3:0];
    case (r_state)
      ST_ATTACK:        w_rate_idx = r_ad[7:4];
      ST_DECAY_SUSTAIN: w_rate_idx = r_ad[3:0];
      default:          w_rate_idx = r_sr[3:0];
    endcase
    w_period = 15'd9;
    case (w_rate_idx)
      4'd0:  w_period = 15'd9;
      4'd1:  w_period = 15'd32;
      4'd2:  w_period = 15'd63;
      4'd3:  w_period = 15'd95;
      4'd4:  w_period = 15'd149;
      4'd5:  w_period = 15'd220;
      4'd6:  w_period = 15'd267;
      4'd7:  w_period = 15'd313;
      4'd8:  w_period = 15'd392;
      4'd9:  w_period = 15'd977;
      4'd10: w_period = 15'd1954;
      4'd11: w_period = 15'd3126;
      4'd12: w_period = 15'd3907;
      4'd13: w_period = 15'd11720;
      4'd14: w_period = 15'd19532;
      default: w_period = 15'd31251;
    endcase
  end

  always_comb begin
    w_exp_top = 5'd30;
    if      (r_env > 8'h5D) w_exp_top = 5'd1;
    else if (r_env > 8'h36) w_exp_top = 5'd2;
    else if (r_env > 8'h1A) w_exp_top = 5'd4;
    else if (r_env > 8'h0E) w_exp_top = 5'd8;
    else if (r_env > 8'h06) w_exp_top = 5'd16;
  end

  // Tick is judged with the old state's rule; a gate edge on the same CLKen
  // only redirects the state, it never cancels the step already taken.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_exp_nxt   = r_exp_cnt;
    w_exp_inc   = r_exp_cnt + 5'd1;
    w_tick      = (r_rate_cnt == w_period);
    w_rate_nxt  = w_tick ? '0 : r_rate_cnt + 15'd1;
    w_rise      = r_gate & ~r_gate_lag;
    w_fall      = ~r_gate & r_gate_lag;
    if (w_tick) begin
      if (r_state == ST_ATTACK) begin
        if (r_env != 8'hFF) w_env_nxt = r_env + 8'd1;
        if (r_env >= 8'hFE) w_state_nxt = ST_DECAY_SUSTAIN;
      end else if (w_exp_inc >= w_exp_top) begin
        w_exp_nxt = '0;
        if (r_state == ST_DECAY_SUSTAIN) begin
          if (r_env > {r_sr[7:4], r_sr[7:4]}) w_env_nxt = r_env - 8'd1;
        end else if (r_env != 8'h00) begin
          w_env_nxt = r_env - 8'd1;
        end
      end else begin
        w_exp_nxt = w_exp_inc;
      end
    end
    if (w_rise) begin
      w_state_nxt = ST_ATTACK;
      w_exp_nxt   = '0;
    end else if (w_fall) begin
      w_state_nxt = ST_RELEASE;
    end
  end

  assign w_prod   = r_vca_s * $signed({1'b0, r_vca_env});
  assign w_unused = ^{w_prod[20], w_prod[3:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vca_s   <= '0;
      r_vca_env <= '0;
      r_out     <= '0;
    end else begin
      r_vca_s   <= $signed({1'b0, VOICE_IN}) - 13'sd2048;
      r_vca_env <= r_env;
      r_out     <= w_prod[19:4];
    end
  end

  assign ENV_OUT = r_env;
  assign OUTPUT  = r_out;

endmodule

// File: tb/tb_sid_envelope.sv
// Scoreboard bench for sid_envelope: stimulus queues expected envelope changes
// and timed samples; a negedge monitor pops and compares them.
module tb_sid_envelope;

  localparam logic [4:0] BASE   = 5'd0;
  localparam logic [4:0] A_CTRL = BASE + 5'd4;
  localparam logic [4:0] A_AD   = BASE + 5'd5;
  localparam logic [4:0] A_SR   = BASE + 5'd6;

  logic        CLK = 1'b0;
  logic        RST, CLKen, WR;
  logic [4:0]  ADDR;
  logic [7:0]  DATA;
  logic [11:0] VOICE_IN;
  logic [7:0]  ENV_OUT;
  logic [15:0] OUTPUT;

  sid_envelope #(.BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .VOICE_IN(VOICE_IN), .ENV_OUT(ENV_OUT), .OUTPUT(OUTPUT)
  );

  always #5 CLK = ~CLK;

  typedef struct { string name; int val; int at; int gap; } chg_t;
  typedef struct { string name; bit is_out; int val; int at; } smp_t;

  chg_t q_chg[$];
  smp_t q_smp[$];
  int   cyc = 0, last_chg = 0, n_checks = 0, n_fail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_env = '0;

  logic [11:0] vin  [6] = '{12'hFFF, 12'h000, 12'h800, 12'h900, 12'h7FF, 12'h001};
  int          vexp [6] = '{32624, -32640, 0, 4080, -16, -32625};

  function automatic void check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void push_chg(string n, int v, int at, int gap);
    q_chg.push_back('{n, v, at, gap});
  endfunction

  function automatic void push_smp(string n, bit is_out, int v, int at);
    q_smp.push_back('{n, is_out, v, at});
  endfunction

  // Exponential divider factor as a function of the envelope before a step.
  function automatic int efac(int v);
    if (v > 'h5D) return 1;
    if (v > 'h36) return 2;
    if (v > 'h1A) return 4;
    if (v > 'h0E) return 8;
    if (v > 'h06) return 16;
    return 30;
  endfunction

  always @(negedge CLK) begin : monitor
    smp_t s;
    chg_t c;
    cyc++;
    while (q_smp.size() > 0 && q_smp[0].at <= cyc) begin
      s = q_smp.pop_front();
      if (s.at != cyc) check({s.name, "_missed"}, cyc, s.at);
      else check(s.name, s.is_out ? int'($signed(OUTPUT)) : int'(ENV_OUT), s.val);
    end
    if (mon_en && ENV_OUT !== prev_env) begin
      if (q_chg.size() == 0) begin
        check("unexpected_env_change", int'(ENV_OUT), int'(prev_env));
      end else begin
        c = q_chg.pop_front();
        check(c.name, int'(ENV_OUT), c.val);
        if (c.at >= 0) check({c.name, "_cycle"}, cyc, c.at);
        if (c.gap > 0) check({c.name, "_gap"}, cyc - last_chg, c.gap);
      end
      last_chg = cyc;
    end
    prev_env = ENV_OUT;
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wr(logic [4:0] a, logic [7:0] d);
    WR = 1'b1; ADDR = a; DATA = d; CLKen = 1'b0;
    step(1);
    WR = 1'b0;
  endtask

  // mode 0: CLKen low, 1: every cycle, 2: every other cycle starting high
  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      CLKen = (mode == 2) ? (i % 2 == 0) : (mode == 1);
      step(1);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0; RST = 1'b1; WR = 1'b0; CLKen = 1'b0;
    step(2);
    RST = 1'b0;
    step(1);
    mon_en = 1'b1;
  endtask

  initial begin : stim
    chg_t c;
    smp_t s;
    int   c0;
    RST = 1'b1; CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0; VOICE_IN = 12'h800;
    do_reset();

    // Attack at P=9 with sustain 'hFF: +1 every 10 CLKen, then hold.
    wr(A_AD, 8'h00); wr(A_SR, 8'hF0); wr(A_CTRL, 8'h01);
    c0 = cyc;
    for (int v = 1; v <= 255; v++)
      push_chg($sformatf("attack_env_%0d", v), v, (v == 1) ? c0 + 10 : -1, (v == 1) ? 0 : 10);
    run(2600, 1);
    run(300, 1);
    push_smp("attack_hold_env", 1'b0, 255, cyc + 1);
    step(1);

    // VCA at env 'hFF, two-cycle latency.
    for (int i = 0; i < 6; i++) begin
      VOICE_IN = vin[i];
      push_smp($sformatf("vca_%03h", vin[i]), 1'b1, vexp[i], cyc + 2);
      step(1);
    end
    step(3);

    // Reset mid-operation, with a competing gate write that reset must override.
    VOICE_IN = 12'hFFF;
    mon_en = 1'b0; RST = 1'b1; WR = 1'b1; ADDR = A_CTRL; DATA = 8'h01; CLKen = 1'b1;
    push_smp("rst_env", 1'b0, 0, cyc + 1);
    push_smp("rst_out", 1'b1, 0, cyc + 1);
    step(1);
    RST = 1'b0; WR = 1'b0;
    step(1);
    mon_en = 1'b1;
    run(10000, 1);
    push_smp("rst_hold_env", 1'b0, 0, cyc + 1);
    push_smp("rst_hold_out", 1'b1, 0, cyc + 1);
    step(1);

    // Decay to sustain 'h88 with CLKen every other cycle.
    do_reset();
    wr(A_AD, 8'h00); wr(A_SR, 8'h80); wr(A_CTRL, 8'h01);
    c0 = cyc;
    for (int v = 1; v <= 255; v++)
      push_chg($sformatf("ds_attack_env_%0d", v), v, (v == 1) ? c0 + 19 : -1, (v == 1) ? 0 : 20);
    for (int v = 254; v >= 136; v--)
      push_chg($sformatf("decay_env_%0d", v), v, -1, 20);
    run(7600, 2);
    run(400, 2);
    push_smp("sustain_hold_env", 1'b0, 'h88, cyc + 1);
    step(1);

    // Release from 'h88 to 0 with exponential spacing, then hold at 0.
    wr(A_CTRL, 8'h00);
    for (int v = 135; v >= 0; v--)
      push_chg($sformatf("release_env_%0d", v), v, -1, (v == 135) ? 0 : 10 * efac(v + 1));
    run(7000, 1);
    run(5000, 1);
    push_smp("release_hold_env", 1'b0, 0, cyc + 1);
    step(1);

    // Gate pulse entirely between two CLKen is ignored.
    wr(A_CTRL, 8'h01); wr(A_CTRL, 8'h00);
    run(500, 1);
    push_smp("pulse_ignored_env", 1'b0, 0, cyc + 1);
    step(1);

    // Rate counter bug: counter at 20000 when P drops to 9, so it wraps first.
    do_reset();
    wr(A_AD, 8'hF0); wr(A_CTRL, 8'h01);
    c0 = cyc;
    run(20000, 1);
    wr(A_AD, 8'h00);
    push_chg("ratebug_env_1", 1, c0 + 32779, 0);
    push_chg("ratebug_env_2", 2, -1, 10);
    run(12790, 1);
    step(2);

    while (q_chg.size() > 0) begin
      c = q_chg.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s_missing: got no change, expected env %0d", c.name, c.val);
    end
    while (q_smp.size() > 0) begin
      s = q_smp.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s_missing: got no sample, expected %0d at cycle %0d", s.name, s.val, s.at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
